// File: rtl/ahbl_bus_mux_n.sv
// AHB-Lite interconnect slice: one master to NSLAVES slaves with address decode,
// data-phase response mux and an internal default slave answering unmapped accesses with ERROR.
module ahbl_bus_mux_n #(
    parameter int                            NSLAVES    = 4,
    parameter int                            ADDR_WIDTH = 32,
    parameter int                            DATA_WIDTH = 32,
    parameter logic [NSLAVES*ADDR_WIDTH-1:0] BASE       = '0,
    parameter logic [NSLAVES*ADDR_WIDTH-1:0] MASK       = '0
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [ADDR_WIDTH-1:0]         HADDR,
    input  logic [1:0]                    HTRANS,
    output logic                          HREADY,
    output logic [DATA_WIDTH-1:0]         HRDATA,
    output logic                          HRESP,
    output logic [NSLAVES-1:0]            HSEL,
    input  logic [NSLAVES-1:0]            HREADYOUT_S,
    input  logic [NSLAVES-1:0]            HRESP_S,
    input  logic [NSLAVES*DATA_WIDTH-1:0] HRDATA_S
);

    localparam int                DSEL_W   = $clog2(NSLAVES + 2);
    localparam logic [DSEL_W-1:0] SEL_NONE = DSEL_W'(NSLAVES);
    localparam logic [DSEL_W-1:0] SEL_DFLT = DSEL_W'(NSLAVES + 1);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    logic [DSEL_W-1:0] dsel;
    logic [DSEL_W-1:0] win_idx;
    logic              dflt_hit;
    logic              accept_dflt;
    ds_state_e         ds_state;
    logic              ds_hready;
    logic              ds_hresp;

    // Walk downwards so the lowest-indexed matching region overrides any higher one.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path
        // that leaves one unassigned infers a latch.
        HSEL     = '0;
        win_idx  = '0;
        dflt_hit = 1'b1;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((HADDR & MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                HSEL     = '0;
                HSEL[i]  = 1'b1;
                win_idx  = DSEL_W'(i);
                dflt_hit = 1'b0;
            end
        end
    end

    assign accept_dflt = HREADY && HTRANS[1] && dflt_hit;

    always_ff @(posedge HCLK) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!HRESETn) begin
            dsel      <= SEL_NONE;
            ds_state  <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= 1'b0;
        end else begin
            if (HREADY) begin
                case (HTRANS)
                    2'b10, 2'b11: dsel <= dflt_hit ? SEL_DFLT : win_idx;
                    default:      dsel <= SEL_NONE;
                endcase
            end

            case (ds_state)
                DS_IDLE: begin
                    if (accept_dflt) begin
                        ds_state  <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= 1'b1;
                    end
                end
                DS_ERR1: begin
                    ds_state  <= DS_ERR2;
                    ds_hready <= 1'b1;
                    ds_hresp  <= 1'b1;
                end
                DS_ERR2: begin
                    if (accept_dflt) begin
                        ds_state  <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= 1'b1;
                    end else begin
                        ds_state  <= DS_IDLE;
                        ds_hready <= 1'b1;
                        ds_hresp  <= 1'b0;
                    end
                end
                default: begin
                    ds_state  <= DS_IDLE;
                    ds_hready <= 1'b1;
                    ds_hresp  <= 1'b0;
                end
            endcase
        end
    end

    // NONE falls through to the zero-wait OKAY defaults.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (dsel == DSEL_W'(i)) begin
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
                HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (dsel == SEL_DFLT) begin
            HREADY = ds_hready;
            HRESP  = ds_hresp;
        end
    end

endmodule

// File: tb/tb_ahbl_bus_mux_n.sv
// Bench for ahbl_bus_mux_n: directed and random cycles against a transfer-level
// reference model, with expectations queued to an independent negedge monitor.
module tb_ahbl_bus_mux_n;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [NS*AW-1:0] BASE_P = {32'h3000_0000, 32'h0000_1000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK_P = {32'hF000_0000, 32'h0000_F000, 32'hF000_0000, 32'hF000_0000};
    localparam logic [NS*DW-1:0] DATA_FIX = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    // Region table as the model sees it: index -> {base, mask}.
    logic [31:0] ref_base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_1000, 32'h3000_0000};
    logic [31:0] ref_mask [NS] = '{32'hF000_0000, 32'hF000_0000, 32'h0000_F000, 32'hF000_0000};

    logic              HCLK;
    logic              HRESETn;
    logic [AW-1:0]     HADDR;
    logic [1:0]        HTRANS;
    logic              HREADY;
    logic [DW-1:0]     HRDATA;
    logic              HRESP;
    logic [NS-1:0]     HSEL;
    logic [NS-1:0]     HREADYOUT_S;
    logic [NS-1:0]     HRESP_S;
    logic [NS*DW-1:0]  HRDATA_S;

    ahbl_bus_mux_n #(
        .NSLAVES   (NS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BASE      (BASE_P),
        .MASK      (MASK_P)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP),
        .HSEL       (HSEL),
        .HREADYOUT_S(HREADYOUT_S),
        .HRESP_S    (HRESP_S),
        .HRDATA_S   (HRDATA_S)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [NS-1:0] hsel;
        logic          hready;
        logic          hresp;
        logic [DW-1:0] hrdata;
    } exp_t;

    typedef enum {P_NONE, P_SLV, P_ERR} pend_e;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    // Pending data phase as seen by the master: nothing, a slave transfer, or an error reply.
    pend_e pk         = P_NONE;
    int    pidx       = 0;
    bit    perr_first = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] addr);
        for (int i = 0; i < NS; i++)
            if ((addr & ref_mask[i]) == (ref_base[i] & ref_mask[i])) return i;
        return -1;
    endfunction

    task automatic cycle(input logic rst_n, input logic [31:0] addr, input logic [1:0] trans,
                         input logic [NS-1:0] rdy_s, input logic [NS-1:0] resp_s,
                         input logic [NS*DW-1:0] data_s);
        exp_t e;
        int   hit;
        @(posedge HCLK);
        #1;
        HRESETn     = rst_n;
        HADDR       = addr;
        HTRANS      = trans;
        HREADYOUT_S = rdy_s;
        HRESP_S     = resp_s;
        HRDATA_S    = data_s;

        hit    = ref_decode(addr);
        e.hsel = '0;
        if (hit >= 0) e.hsel[hit] = 1'b1;
        case (pk)
            P_SLV: begin
                e.hready = rdy_s[pidx];
                e.hresp  = resp_s[pidx];
                e.hrdata = data_s[pidx*DW +: DW];
            end
            P_ERR: begin
                e.hready = !perr_first;
                e.hresp  = 1'b1;
                e.hrdata = '0;
            end
            default: begin
                e.hready = 1'b1;
                e.hresp  = 1'b0;
                e.hrdata = '0;
            end
        endcase
        exp_q.push_back(e);

        if (!rst_n) begin
            pk = P_NONE;
        end else if (e.hready) begin
            if (trans[1]) begin
                if (hit >= 0) begin
                    pk   = P_SLV;
                    pidx = hit;
                end else begin
                    pk         = P_ERR;
                    perr_first = 1'b1;
                end
            end else begin
                pk = P_NONE;
            end
        end else if (pk == P_ERR) begin
            perr_first = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hsel",   64'(HSEL),   64'(e.hsel));
                check("hready", 64'(HREADY), 64'(e.hready));
                check("hresp",  64'(HRESP),  64'(e.hresp));
                check("hrdata", 64'(HRDATA), 64'(e.hrdata));
            end
            cyc++;
        end
    end

    initial begin
        logic [31:0]    addr;
        logic [NS-1:0]  rdy;
        logic [NS*DW-1:0] data;

        HRESETn     = 1'b0;
        HADDR       = 32'h2000_1040;
        HTRANS      = T_NSEQ;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        HRDATA_S    = DATA_FIX;

        // Reset held with a NONSEQ presented
        repeat (3) cycle(1'b0, 32'h2000_1040, T_NSEQ, 4'hF, 4'h0, DATA_FIX);

        // Decode to slave 2, then its data phase while slave 1 is addressed
        cycle(1'b1, 32'h2000_1040, T_NSEQ, 4'hF, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h1000_0000, T_NSEQ, 4'hF, 4'h0, DATA_FIX);

        // Slave 1 stalls for three cycles while slave 3 waits in the address phase
        repeat (3) cycle(1'b1, 32'h3000_0000, T_NSEQ, 4'b1101, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h3000_0000, T_NSEQ, 4'hF, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h0000_0000, T_IDLE, 4'hF, 4'h0, DATA_FIX);

        // Single unmapped access
        cycle(1'b1, 32'h5000_0000, T_NSEQ, 4'hF, 4'h0, DATA_FIX);
        repeat (3) cycle(1'b1, 32'h0000_0000, T_IDLE, 4'hF, 4'h0, DATA_FIX);

        // Back-to-back unmapped accesses
        cycle(1'b1, 32'h5000_0000, T_NSEQ, 4'hF, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h6000_0000, T_SEQ,  4'hF, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h6000_0000, T_SEQ,  4'hF, 4'h0, DATA_FIX);
        repeat (3) cycle(1'b1, 32'h0000_0000, T_IDLE, 4'hF, 4'h0, DATA_FIX);

        // IDLE and BUSY to a mapped address ignore the slave's response
        cycle(1'b1, 32'h1000_0000, T_IDLE, 4'hF, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h1000_0000, T_BUSY, 4'h0, 4'hF, DATA_FIX);
        cycle(1'b1, 32'h0000_0000, T_IDLE, 4'h0, 4'hF, DATA_FIX);

        // Overlapping regions 0 and 2: the lower index wins
        cycle(1'b1, 32'h0000_1000, T_NSEQ, 4'hF, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h0000_0000, T_IDLE, 4'hF, 4'h0, DATA_FIX);

        // Slave wait-state ERROR passes through untouched
        cycle(1'b1, 32'h1000_0000, T_NSEQ, 4'hF, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h0000_0000, T_IDLE, 4'b1101, 4'b0010, DATA_FIX);
        cycle(1'b1, 32'h0000_0000, T_IDLE, 4'hF, 4'b0010, DATA_FIX);

        // Reset during the first error cycle drops the error reply
        cycle(1'b1, 32'h5000_0000, T_NSEQ, 4'hF, 4'h0, DATA_FIX);
        cycle(1'b0, 32'h0000_0000, T_IDLE, 4'hF, 4'h0, DATA_FIX);
        cycle(1'b1, 32'h0000_0000, T_IDLE, 4'hF, 4'h0, DATA_FIX);

        // Random traffic with occasional resets
        repeat (600) begin
            addr         = $urandom;
            addr[31:28]  = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) addr[15:12] = 4'h1;
            for (int i = 0; i < NS; i++) begin
                rdy[i]             = ($urandom_range(0, 3) != 0);
                data[i*DW +: DW]   = $urandom;
            end
            cycle(($urandom_range(0, 49) != 0), addr, 2'($urandom), rdy, 4'($urandom), data);
        end
        cycle(1'b1, 32'h0000_0000, T_IDLE, 4'hF, 4'h0, DATA_FIX);

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahbl_bus_mux_n.md
Name: ahbl_bus_mux_n

Overview:
- Parametrised AHB-Lite interconnect slice between one master and NSLAVES slaves.
- Decodes HADDR into one-hot HSEL and registers the address-phase select into the data phase.
- Muxes HRDATA/HREADYOUT/HRESP back to the master.
- Unmapped accesses go to an internal default slave that gives the two-cycle ERROR response.

Parameters:
- NSLAVES, 4, number of slave ports (1..16)
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HRDATA width
- BASE, {NSLAVES{32'h0}}, packed NSLAVES*ADDR_WIDTH vector; region i base address
- MASK, {NSLAVES{32'h0}}, packed NSLAVES*ADDR_WIDTH vector; region i compare mask

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  synchronous active-low reset
- HADDR  in  ADDR_WIDTH  master address-phase address
- HTRANS  in  2  master transfer type
- HREADY  out  1  muxed ready to master; also broadcast to slaves as HREADY input
- HRDATA  out  DATA_WIDTH  muxed read data to master
- HRESP  out  1  muxed response to master
- HSEL  out  NSLAVES  one-hot slave select (combinational, address phase)
- HREADYOUT_S  in  NSLAVES  per-slave HREADYOUT
- HRESP_S  in  NSLAVES  per-slave HRESP
- HRDATA_S  in  NSLAVES*DATA_WIDTH  per-slave HRDATA, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Decode:
  - Region i hits when (HADDR & MASK[i]) == (BASE[i] & MASK[i]).
  - Multiple hits: lowest index wins; HSEL is always one-hot or zero.
  - HSEL is driven from HADDR regardless of HTRANS, per AHB-Lite.
  - dflt_hit = no region hits.
- Data-phase select register (dsel, ceil(log2(NSLAVES+2)) bits):
  - Encodings: 0..NSLAVES-1 = slave; NSLAVES = NONE; NSLAVES+1 = DEFAULT.
  - Loads only when HREADY==1.
  - Load value:
    - HTRANS[1]==1 and a region hits → winning index.
    - HTRANS[1]==1 and dflt_hit → DEFAULT.
    - HTRANS IDLE or BUSY → NONE.
  - Holds while HREADY==0.
- Response mux (combinational from dsel):
  - Slave i: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=slave i slice.
  - NONE: HREADY=1, HRESP=0 (OKAY), HRDATA=0; zero-wait.
  - DEFAULT: driven by the default-slave FSM below; HRDATA=0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE → DS_ERR1 when HREADY==1 and HTRANS[1]==1 and dflt_hit.
  - DS_ERR1: HREADY=0, HRESP=1; → DS_ERR2 unconditionally.
  - DS_ERR2: HREADY=1, HRESP=1; → DS_ERR1 if another unmapped NONSEQ/SEQ is accepted this cycle, else DS_IDLE.
  - DS_IDLE outputs: not used for the mux (dsel≠DEFAULT).
- Latency:
  - Mapped slave: HREADY follows the slave; the block adds 0 cycles.
  - Unmapped: exactly 2 data-phase cycles.
  - Back-to-back unmapped transfers: ERR1, ERR2, ERR1, ERR2…
- Reset (HRESETn==0 at posedge): dsel=NONE, FSM=DS_IDLE. The next cycle gives HREADY=1, HRESP=0, HRDATA=0.
  - HSEL stays combinational during reset.
  - Reset mid-transfer (including mid-ERROR) drops the pending data phase immediately.
- Slave wait-state ERROR (HRESP_S=1 with HREADYOUT_S=0) passes through unmodified; the block does not check slave protocol.
- NSLAVES==1 must synthesise; index widths are computed with $clog2.

Test Plan:
- Reset: hold HRESETn=0 for 3 cycles, HTRANS=NONSEQ → HREADY=1, HRESP=0, HRDATA=0; dsel=NONE after release.
- Decode and mux:
  - Setup: NSLAVES=4, BASE={0x3000_0000,0x2000_0000,0x1000_0000,0x0}, MASK=0xF000_0000 each.
  - NONSEQ to 0x2000_0040 → HSEL=4'b0100 in the address phase.
  - Next cycle HRDATA=HRDATA_S slice 2 (0xCAFE_0002), HREADY=HREADYOUT_S[2].
- Wait-state propagation:
  - Slave 1 holds HREADYOUT_S[1]=0 for 3 cycles while the master presents NONSEQ to slave 3.
  - dsel stays 1 and HREADY=0 for 3 cycles; slave 3 data phase starts only after HREADYOUT_S[1]=1.
- Unmapped access:
  - Setup: MASK[0]=0xF000_0000, BASE[0]=0; only region 0 mapped.
  - NONSEQ to 0x5000_0000 → HSEL=0; next cycle HREADY=0/HRESP=1; following cycle HREADY=1/HRESP=1.
  - Two consecutive unmapped NONSEQs → ERR1, ERR2, ERR1, ERR2 with no OKAY gap.
- IDLE/BUSY: HTRANS=IDLE to a mapped address → HSEL asserted, next cycle HREADY=1, HRESP=0, HRDATA=0, and the slave's HREADYOUT is ignored.
- Overlap priority and reset mid-error:
  - Regions 0 and 2 both match 0x0000_1000 → HSEL=4'b0001.
  - Reset asserted in DS_ERR1 → next cycle HREADY=1, HRESP=0.
